// File: rtl/axi_lite_reg_slice_pkg.sv
// Shared constants and payload types for the AXI-lite register slice.
package axi_lite_reg_slice_pkg;

    // Per-channel stage modes.
    localparam int SLICE_BYPASS  = 0;
    localparam int SLICE_FORWARD = 1;
    localparam int SLICE_FULL    = 2;

    typedef logic [1:0] resp_t;
    typedef logic [2:0] prot_t;

endpackage

// File: rtl/axi_lite_reg_slice_if.sv
// AXI-lite link bundle. The master drives requests (AW/W/AR) and accepts
// responses (B/R); the slave is the mirror image.
interface axi_lite_reg_slice_if #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 64
) ();
    import axi_lite_reg_slice_pkg::*;

    logic [AddrWidth-1:0]   aw_addr;
    prot_t                  aw_prot;
    logic                   aw_valid;
    logic                   aw_ready;

    logic [DataWidth-1:0]   w_data;
    logic [DataWidth/8-1:0] w_strb;
    logic                   w_valid;
    logic                   w_ready;

    resp_t                  b_resp;
    logic                   b_valid;
    logic                   b_ready;

    logic [AddrWidth-1:0]   ar_addr;
    prot_t                  ar_prot;
    logic                   ar_valid;
    logic                   ar_ready;

    logic [DataWidth-1:0]   r_data;
    resp_t                  r_resp;
    logic                   r_valid;
    logic                   r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

endinterface

// File: rtl/axi_lite_reg_slice_stage.sv
// Generic single-channel valid/ready stage: bypass wires, a forward
// register, or a full skid buffer that also registers the ready path.
module axi_lite_slice_stage
    import axi_lite_reg_slice_pkg::*;
#(
    parameter int Width = 8,
    parameter int Mode  = SLICE_FULL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [Width-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [Width-1:0] dn_data
);

    if (Mode == SLICE_BYPASS) begin : g_bypass
        assign dn_valid = up_valid;
        assign up_ready = dn_ready;
        assign dn_data  = up_data;
    end else if (Mode == SLICE_FORWARD) begin : g_forward
        logic             valid_q;
        logic [Width-1:0] data_q;
        logic             up_xfer;

        // Ready stays combinational from dn_ready so a draining beat frees
        // the slot in the same cycle.
        assign up_ready = !valid_q || dn_ready;
        assign up_xfer  = up_valid && up_ready;
        assign dn_valid = valid_q;
        assign dn_data  = data_q;

        // Occupancy of the single register stage.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
            end else if (up_xfer) begin
                valid_q <= 1'b1;
            end else if (dn_ready) begin
                valid_q <= 1'b0;
            end
        end

        // Payload capture; no reset since it is ignored while valid_q is low.
        always_ff @(posedge clk_i) begin
            if (up_xfer) begin
                data_q <= up_data;
            end
        end
    end else begin : g_full
        logic             valid_q;
        logic             skid_valid;
        logic             ready_q;
        logic [Width-1:0] data_q;
        logic [Width-1:0] skid_data;
        logic             up_xfer;
        logic             dn_xfer;
        logic             skid_load;
        logic             next_skid_valid;

        assign up_ready = ready_q;
        assign dn_valid = valid_q;
        assign dn_data  = data_q;

        assign up_xfer  = up_valid && ready_q;
        assign dn_xfer  = valid_q && dn_ready;
        // A beat accepted while the main register is stuck parks in the skid.
        assign skid_load       = up_xfer && valid_q && !dn_ready;
        assign next_skid_valid = skid_valid ? !dn_xfer : skid_load;

        // Occupancy flags and the registered ready; ready_q is held low in
        // reset and rises on the first edge afterwards.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q    <= 1'b0;
                skid_valid <= 1'b0;
                ready_q    <= 1'b0;
            end else begin
                skid_valid <= next_skid_valid;
                ready_q    <= !next_skid_valid;
                if (up_xfer) begin
                    valid_q <= 1'b1;
                end else if (dn_xfer && !skid_valid) begin
                    valid_q <= 1'b0;
                end
            end
        end

        // Payload movement: skid refills main first, otherwise new beats land
        // in main unless they must be parked.
        always_ff @(posedge clk_i) begin
            if (skid_valid && dn_xfer) begin
                data_q <= skid_data;
            end else if (up_xfer && !skid_load) begin
                data_q <= up_data;
            end
            if (skid_load) begin
                skid_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/axi_lite_reg_slice.sv
// AXI-lite register slice: five independent channel stages between the
// bridge (host) and the BRAM controller (device).
module axi_lite_reg_slice
    import axi_lite_reg_slice_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 64,
    parameter int AW_MODE   = 2,
    parameter int W_MODE    = 2,
    parameter int B_MODE    = 2,
    parameter int AR_MODE   = 2,
    parameter int R_MODE    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi_lite_reg_slice_if.slave   host,
    axi_lite_reg_slice_if.master  device
);

    localparam int AwWidth = AddrWidth + 3;
    localparam int WWidth  = DataWidth + DataWidth / 8;
    localparam int BWidth  = 2;
    localparam int ArWidth = AddrWidth + 3;
    localparam int RWidth  = DataWidth + 2;

    logic [AwWidth-1:0] aw_up, aw_dn;
    logic [WWidth-1:0]  w_up, w_dn;
    logic [BWidth-1:0]  b_up, b_dn;
    logic [ArWidth-1:0] ar_up, ar_dn;
    logic [RWidth-1:0]  r_up, r_dn;

    assign aw_up = {host.aw_addr, host.aw_prot};
    assign {device.aw_addr, device.aw_prot} = aw_dn;
    assign w_up  = {host.w_data, host.w_strb};
    assign {device.w_data, device.w_strb} = w_dn;
    assign b_up  = device.b_resp;
    assign host.b_resp = b_dn;
    assign ar_up = {host.ar_addr, host.ar_prot};
    assign {device.ar_addr, device.ar_prot} = ar_dn;
    assign r_up  = {device.r_data, device.r_resp};
    assign {host.r_data, host.r_resp} = r_dn;

    axi_lite_slice_stage #(.Width(AwWidth), .Mode(AW_MODE)) u_aw (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (host.aw_valid),
        .up_ready (host.aw_ready),
        .up_data  (aw_up),
        .dn_valid (device.aw_valid),
        .dn_ready (device.aw_ready),
        .dn_data  (aw_dn)
    );

    axi_lite_slice_stage #(.Width(WWidth), .Mode(W_MODE)) u_w (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (host.w_valid),
        .up_ready (host.w_ready),
        .up_data  (w_up),
        .dn_valid (device.w_valid),
        .dn_ready (device.w_ready),
        .dn_data  (w_dn)
    );

    axi_lite_slice_stage #(.Width(BWidth), .Mode(B_MODE)) u_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (device.b_valid),
        .up_ready (device.b_ready),
        .up_data  (b_up),
        .dn_valid (host.b_valid),
        .dn_ready (host.b_ready),
        .dn_data  (b_dn)
    );

    axi_lite_slice_stage #(.Width(ArWidth), .Mode(AR_MODE)) u_ar (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (host.ar_valid),
        .up_ready (host.ar_ready),
        .up_data  (ar_up),
        .dn_valid (device.ar_valid),
        .dn_ready (device.ar_ready),
        .dn_data  (ar_dn)
    );

    axi_lite_slice_stage #(.Width(RWidth), .Mode(R_MODE)) u_r (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (device.r_valid),
        .up_ready (device.r_ready),
        .up_data  (r_up),
        .dn_valid (host.r_valid),
        .dn_ready (host.r_ready),
        .dn_data  (r_dn)
    );

endmodule

// File: tb/tb_axi_lite_reg_slice.sv
// Directed bench for the register slice: AW/W/B full, AR bypass, R forward.
module tb_axi_lite_reg_slice;
    import axi_lite_reg_slice_pkg::*;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int NBEATS = 1000;

    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_fails;

    axi_lite_reg_slice_if #(.DataWidth(DW), .AddrWidth(AW)) host_if ();
    axi_lite_reg_slice_if #(.DataWidth(DW), .AddrWidth(AW)) device_if ();

    axi_lite_reg_slice #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .AW_MODE   (SLICE_FULL),
        .W_MODE    (SLICE_FULL),
        .B_MODE    (SLICE_FULL),
        .AR_MODE   (SLICE_BYPASS),
        .R_MODE    (SLICE_FORWARD)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .host   (host_if.slave),
        .device (device_if.master)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] wdat(input int i);
        return 64'hDA7A_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [63:0] rdat(input int i);
        return 64'h5EED_0000_0000_0000 ^ (64'(i) * 64'd7);
    endfunction

    function automatic logic [63:0] aradr(input int i);
        return 64'h4000_0000 + 64'(i) * 64'd8;
    endfunction

    int   w_idx, w_rcv, r_idx, r_rcv, ar_idx, ar_rcv;
    logic w_fire, r_fire, ar_fire;
    logic w_stall, r_stall, ar_stall;
    logic [127:0] w_hold, r_hold, ar_hold;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_i = 1'b1;
        host_if.aw_addr = '0;  host_if.aw_prot = '0;  host_if.aw_valid = 1'b0;
        host_if.w_data  = '0;  host_if.w_strb  = '0;  host_if.w_valid  = 1'b0;
        host_if.b_ready = 1'b1;
        host_if.ar_addr = '0;  host_if.ar_prot = '0;  host_if.ar_valid = 1'b0;
        host_if.r_ready = 1'b1;
        device_if.aw_ready = 1'b1;
        device_if.w_ready  = 1'b1;
        device_if.b_resp   = '0; device_if.b_valid = 1'b0;
        device_if.ar_ready = 1'b1;
        device_if.r_data   = '0; device_if.r_resp  = '0; device_if.r_valid = 1'b0;

        // Reset state.
        @(negedge clk_i);
        check("rst_dev_aw_valid", device_if.aw_valid, 0);
        check("rst_dev_w_valid",  device_if.w_valid, 0);
        check("rst_host_b_valid", host_if.b_valid, 0);
        check("rst_host_r_valid", host_if.r_valid, 0);
        check("rst_host_aw_ready", host_if.aw_ready, 0);
        check("rst_host_w_ready",  host_if.w_ready, 0);
        check("rst_dev_b_ready",   device_if.b_ready, 0);
        check("rst_dev_r_ready_fwd", device_if.r_ready, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("post_rst_aw_ready_low", host_if.aw_ready, 0);
        @(negedge clk_i);
        check("post_rst_aw_ready", host_if.aw_ready, 1);
        check("post_rst_w_ready",  host_if.w_ready, 1);
        check("post_rst_b_ready",  device_if.b_ready, 1);

        // AW full mode, three back-to-back beats.
        cyc();
        host_if.aw_valid = 1'b1; host_if.aw_addr = 64'h10; host_if.aw_prot = 3'd1;
        @(negedge clk_i);
        check("aw0_dev_valid", device_if.aw_valid, 0);
        check("aw0_ready", host_if.aw_ready, 1);
        cyc();
        host_if.aw_addr = 64'h18; host_if.aw_prot = 3'd2;
        @(negedge clk_i);
        check("aw1_dev_valid", device_if.aw_valid, 1);
        check("aw1_dev_addr", device_if.aw_addr, 64'h10);
        check("aw1_dev_prot", device_if.aw_prot, 3'd1);
        check("aw1_ready", host_if.aw_ready, 1);
        cyc();
        host_if.aw_addr = 64'h20; host_if.aw_prot = 3'd3;
        @(negedge clk_i);
        check("aw2_dev_addr", device_if.aw_addr, 64'h18);
        check("aw2_ready", host_if.aw_ready, 1);
        cyc();
        host_if.aw_valid = 1'b0;
        @(negedge clk_i);
        check("aw3_dev_valid", device_if.aw_valid, 1);
        check("aw3_dev_addr", device_if.aw_addr, 64'h20);
        cyc();
        @(negedge clk_i);
        check("aw4_dev_valid", device_if.aw_valid, 0);

        // W full mode with a stalled sink: fill main then skid.
        cyc();
        device_if.w_ready = 1'b0;
        host_if.w_valid = 1'b1; host_if.w_data = 64'hA; host_if.w_strb = 8'hFF;
        @(negedge clk_i);
        check("wA_ready", host_if.w_ready, 1);
        cyc();
        host_if.w_data = 64'hB; host_if.w_strb = 8'h0F;
        @(negedge clk_i);
        check("wB_ready", host_if.w_ready, 1);
        check("wB_dev_data", device_if.w_data, 64'hA);
        cyc();
        host_if.w_valid = 1'b0;
        @(negedge clk_i);
        check("w_full_ready", host_if.w_ready, 0);
        check("w_full_dev_valid", device_if.w_valid, 1);
        check("w_full_dev_data", device_if.w_data, 64'hA);
        cyc();
        @(negedge clk_i);
        check("w_hold_ready", host_if.w_ready, 0);
        check("w_hold_dev_data", device_if.w_data, 64'hA);
        cyc();
        device_if.w_ready = 1'b1;
        @(negedge clk_i);
        check("w_drainA_data", device_if.w_data, 64'hA);
        check("w_drainA_strb", device_if.w_strb, 8'hFF);
        cyc();
        @(negedge clk_i);
        check("w_drainB_valid", device_if.w_valid, 1);
        check("w_drainB_data", device_if.w_data, 64'hB);
        check("w_drainB_strb", device_if.w_strb, 8'h0F);
        check("w_drainB_ready", host_if.w_ready, 1);
        cyc();
        @(negedge clk_i);
        check("w_empty_valid", device_if.w_valid, 0);

        // B full mode, one response.
        cyc();
        device_if.b_valid = 1'b1; device_if.b_resp = 2'b10;
        @(negedge clk_i);
        check("b0_host_valid", host_if.b_valid, 0);
        cyc();
        device_if.b_valid = 1'b0;
        @(negedge clk_i);
        check("b1_host_valid", host_if.b_valid, 1);
        check("b1_host_resp", host_if.b_resp, 2'b10);

        // R forward mode: buffered beat, then combinational ready release.
        cyc();
        host_if.r_ready = 1'b0;
        device_if.r_valid = 1'b1; device_if.r_data = 64'h55; device_if.r_resp = 2'b01;
        @(negedge clk_i);
        check("r0_dev_ready", device_if.r_ready, 1);
        cyc();
        device_if.r_valid = 1'b0;
        @(negedge clk_i);
        check("r1_dev_ready", device_if.r_ready, 0);
        check("r1_host_valid", host_if.r_valid, 1);
        check("r1_host_data", host_if.r_data, 64'h55);
        check("r1_host_resp", host_if.r_resp, 2'b01);
        cyc();
        host_if.r_ready = 1'b1;
        #1;
        check("r2_dev_ready_comb", device_if.r_ready, 1);
        @(negedge clk_i);
        check("r2_host_valid", host_if.r_valid, 1);
        cyc();
        @(negedge clk_i);
        check("r3_host_valid", host_if.r_valid, 0);

        // AR bypass: same-cycle pass-through both directions.
        cyc();
        device_if.ar_ready = 1'b0;
        host_if.ar_valid = 1'b1; host_if.ar_addr = 64'h1234; host_if.ar_prot = 3'd5;
        #1;
        check("ar_dev_valid", device_if.ar_valid, 1);
        check("ar_dev_addr", device_if.ar_addr, 64'h1234);
        check("ar_dev_prot", device_if.ar_prot, 3'd5);
        check("ar_host_ready0", host_if.ar_ready, 0);
        device_if.ar_ready = 1'b1;
        #1;
        check("ar_host_ready1", host_if.ar_ready, 1);
        host_if.ar_valid = 1'b0;
        #1;
        check("ar_dev_valid0", device_if.ar_valid, 0);

        // Reset with the W skid full.
        cyc();
        device_if.w_ready = 1'b0;
        host_if.w_valid = 1'b1; host_if.w_data = 64'h1; host_if.w_strb = 8'h01;
        cyc();
        host_if.w_data = 64'h2;
        cyc();
        host_if.w_valid = 1'b0;
        @(negedge clk_i);
        check("pre_rst_w_full", host_if.w_ready, 0);
        cyc();
        device_if.b_valid = 1'b1;
        rst_i = 1'b1;
        #1;
        check("mid_rst_dev_w_valid", device_if.w_valid, 0);
        check("mid_rst_host_w_ready", host_if.w_ready, 0);
        check("mid_rst_host_aw_ready", host_if.aw_ready, 0);
        check("mid_rst_host_b_valid", host_if.b_valid, 0);
        device_if.b_valid = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rel_w_ready_low", host_if.w_ready, 0);
        @(negedge clk_i);
        check("rel_w_ready_high", host_if.w_ready, 1);
        check("rel_dev_w_valid", device_if.w_valid, 0);
        cyc();
        device_if.w_ready = 1'b1;
        host_if.w_valid = 1'b1; host_if.w_data = 64'hC; host_if.w_strb = 8'hC0;
        @(negedge clk_i);
        check("new_w_dev_valid0", device_if.w_valid, 0);
        cyc();
        host_if.w_valid = 1'b0;
        @(negedge clk_i);
        check("new_w_dev_valid1", device_if.w_valid, 1);
        check("new_w_dev_data", device_if.w_data, 64'hC);
        check("new_w_dev_strb", device_if.w_strb, 8'hC0);
        cyc();

        // Random stall scoreboard on W (full), R (forward), AR (bypass).
        w_idx = 0;  w_rcv = 0;  w_fire = 0;  w_stall = 0;  w_hold = '0;
        r_idx = 0;  r_rcv = 0;  r_fire = 0;  r_stall = 0;  r_hold = '0;
        ar_idx = 0; ar_rcv = 0; ar_fire = 0; ar_stall = 0; ar_hold = '0;
        for (int n = 0; n < 20000 && !(w_rcv == NBEATS && r_rcv == NBEATS && ar_rcv == NBEATS); n++) begin
            @(posedge clk_i);
            #1;
            if (!host_if.w_valid || w_fire) begin
                host_if.w_valid = (w_idx < NBEATS) && ($urandom_range(3) != 0);
                host_if.w_data  = wdat(w_idx);
                host_if.w_strb  = 8'(w_idx);
                w_fire = 1'b0;
            end
            if (!device_if.r_valid || r_fire) begin
                device_if.r_valid = (r_idx < NBEATS) && ($urandom_range(3) != 0);
                device_if.r_data  = rdat(r_idx);
                device_if.r_resp  = 2'(r_idx);
                r_fire = 1'b0;
            end
            if (!host_if.ar_valid || ar_fire) begin
                host_if.ar_valid = (ar_idx < NBEATS) && ($urandom_range(3) != 0);
                host_if.ar_addr  = aradr(ar_idx);
                host_if.ar_prot  = 3'(ar_idx);
                ar_fire = 1'b0;
            end
            device_if.w_ready  = 1'($urandom_range(1));
            host_if.r_ready    = 1'($urandom_range(1));
            device_if.ar_ready = 1'($urandom_range(1));
            @(negedge clk_i);

            if (host_if.w_valid && host_if.w_ready) begin w_idx++; w_fire = 1'b1; end
            if (w_stall) begin
                check("w_stall_valid", device_if.w_valid, 1);
                check("w_stall_data", {device_if.w_data, device_if.w_strb}, w_hold);
            end
            if (device_if.w_valid && device_if.w_ready) begin
                check("w_beat", {device_if.w_data, device_if.w_strb}, {wdat(w_rcv), 8'(w_rcv)});
                w_rcv++;
            end
            w_stall = device_if.w_valid && !device_if.w_ready;
            w_hold  = {device_if.w_data, device_if.w_strb};

            if (device_if.r_valid && device_if.r_ready) begin r_idx++; r_fire = 1'b1; end
            if (r_stall) begin
                check("r_stall_valid", host_if.r_valid, 1);
                check("r_stall_data", {host_if.r_data, host_if.r_resp}, r_hold);
            end
            if (host_if.r_valid && host_if.r_ready) begin
                check("r_beat", {host_if.r_data, host_if.r_resp}, {rdat(r_rcv), 2'(r_rcv)});
                r_rcv++;
            end
            r_stall = host_if.r_valid && !host_if.r_ready;
            r_hold  = {host_if.r_data, host_if.r_resp};

            if (host_if.ar_valid && host_if.ar_ready) begin ar_idx++; ar_fire = 1'b1; end
            if (ar_stall) begin
                check("ar_stall_valid", device_if.ar_valid, 1);
                check("ar_stall_data", {device_if.ar_addr, device_if.ar_prot}, ar_hold);
            end
            if (device_if.ar_valid && device_if.ar_ready) begin
                check("ar_beat", {device_if.ar_addr, device_if.ar_prot}, {aradr(ar_rcv), 3'(ar_rcv)});
                ar_rcv++;
            end
            ar_stall = device_if.ar_valid && !device_if.ar_ready;
            ar_hold  = {device_if.ar_addr, device_if.ar_prot};
        end
        check("rand_w_count", w_rcv, NBEATS);
        check("rand_r_count", r_rcv, NBEATS);
        check("rand_ar_count", ar_rcv, NBEATS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
